// File: rtl/imm_operand_encoder_pkg.sv
// Shared types and constants for the RV32I immediate operand encoder.
//   imm_type_e : immediate encoding type codes carried on in_type
//   enc_req_t  : one captured encode request (type, fields, immediate)
//   NOP_INSTR  : addi x0,x0,0, emitted for any unencodable request
//   imm_fits   : true when a 32-bit value is a sign extension of its low nbits
package imm_operand_encoder_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5
  } imm_type_e;

  // Type is kept as raw bits so unknown codes survive to the range check.
  typedef struct packed {
    logic [2:0]  itype;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_req_t;

  // Every bit from nbits-1 upward must equal the sign bit.
  function automatic logic imm_fits(input logic [31:0] v, input int unsigned nbits);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((i + 1 >= nbits) && (v[i] != v[31])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational packer: scatters the immediate and register/funct fields of one
// request into an RV32I instruction word and flags unrepresentable immediates.
//   req   : captured request
//   instr : packed instruction word, NOP_INSTR when err is set
//   err   : immediate out of range for its type, or unknown type
module imm_scatter
  import imm_operand_encoder_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] instr,
  output logic        err
);

  logic [31:0] word;
  logic        legal;
  logic [31:0] imm;

  assign imm = req.imm;

  // Per-type packing; fields a type does not use never reach the word.
  always_comb begin
    word  = NOP_INSTR;
    legal = 1'b0;
    case (req.itype)
      3'(RTYPE): begin
        word  = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
        legal = 1'b1;
      end
      3'(ITYPE): begin
        word  = {imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        legal = imm_fits(imm, 12);
      end
      3'(STYPE): begin
        word  = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], req.opcode};
        legal = imm_fits(imm, 12);
      end
      3'(BTYPE): begin
        word  = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3, imm[4:1], imm[11], req.opcode};
        legal = imm_fits(imm, 13) && !imm[0];
      end
      3'(UTYPE): begin
        word  = {imm[31:12], req.rd, req.opcode};
        legal = (imm[11:0] == 12'h000);
      end
      3'(JTYPE): begin
        word  = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, req.opcode};
        legal = imm_fits(imm, 21) && !imm[0];
      end
      default: begin
        word  = NOP_INSTR;
        legal = 1'b0;
      end
    endcase
  end

  assign instr = legal ? word : NOP_INSTR;
  assign err   = !legal;

endmodule

// File: rtl/imm_operand_encoder.sv
// Two-stage valid/ready pipeline that encodes opcode/register/funct fields and a
// 32-bit immediate into one RV32I instruction word.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : request handshake (in_ready depends only on state and out_ready)
//   in_type..in_imm   : request fields
//   out_valid/out_ready, out_instr, out_err : encoded word handshake and payload
//   err_count         : saturating count of errored words accepted at the output
module imm_operand_encoder
  import imm_operand_encoder_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  enc_req_t    s1_req;
  logic        s1_valid;
  logic        out_free;
  logic        s1_advance;
  logic [31:0] enc_instr;
  logic        enc_err;

  // A stage may load when the next one is empty or being drained this cycle.
  assign out_free   = !out_valid || out_ready;
  assign s1_advance = s1_valid && out_free;
  assign in_ready   = !s1_valid || s1_advance;

  imm_scatter u_scatter (
    .req   (s1_req),
    .instr (enc_instr),
    .err   (enc_err)
  );

  // Stage registers and error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_req    <= '0;
      out_valid <= 1'b0;
      out_instr <= NOP_INSTR;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_req <= '{itype:  in_type,   opcode: in_opcode, rd:     in_rd,
                    funct3: in_funct3, rs1:    in_rs1,    rs2:    in_rs2,
                    funct7: in_funct7, imm:    in_imm};
      end
      if (out_free) out_valid <= s1_valid;
      if (s1_advance) begin
        out_instr <= enc_instr;
        out_err   <= enc_err;
      end
      if (out_valid && out_ready && out_err && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_operand_encoder.sv
module tb_imm_operand_encoder;
  import imm_operand_encoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_type;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_errs = 0;

  imm_operand_encoder #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_funct3 (in_funct3),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [6:0] f7, input logic [31:0] imm);
    in_type = t; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
  endtask

  // One request through an otherwise idle pipeline with out_ready held high.
  task automatic run1(input string tag, input logic [2:0] t, input logic [6:0] op,
                      input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err);
    int cyc;
    @(negedge clk);
    set_req(t, op, rd, f3, rs1, rs2, f7, imm);
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    if (!in_ready) begin
      check({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, 32'(cyc), 32'd2);
    check({tag, "_instr"}, out_instr, exp_instr);
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
  endtask

  logic [31:0] got[$];
  logic [32:0] sbq[$];

  initial begin
    logic drop;
    logic acc;
    logic [32:0] cur;
    logic [32:0] exp_item;
    int   v;
    int   seen;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_req(3'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Legal encodings; unused fields are deliberately nonzero.
    run1("i_neg1", 3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd31, 7'h7F, 32'hFFFF_FFFF, 32'hFFF00093, 1'b0);
    run1("s_8",    3'(STYPE), 7'b0100011, 5'd31, 3'b010, 5'd1, 5'd2, 7'h7F, 32'd8, 32'h0020A423, 1'b0);
    run1("b_neg4", 3'(BTYPE), 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'h7F, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b0);
    run1("j_2048", 3'(JTYPE), 7'b1101111, 5'd1, 3'd7, 5'd31, 5'd31, 7'h7F, 32'd2048, 32'h001000EF, 1'b0);
    run1("u_lui",  3'(UTYPE), 7'b0110111, 5'd5, 3'd7, 5'd31, 5'd31, 7'h7F, 32'h12345000, 32'h123452B7, 1'b0);
    run1("r_sub",  3'(RTYPE), 7'b0110011, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'hDEAD_BEEF, 32'h403100B3, 1'b0);
    run1("i_max",  3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2047, 32'h7FF00093, 1'b0);
    run1("i_min",  3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_F800, 32'h80000093, 1'b0);
    run1("b_max",  3'(BTYPE), 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4094, 32'h7E000FE3, 1'b0);
    run1("j_neg2", 3'(JTYPE), 7'b1101111, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFE, 32'hFFFFF06F, 1'b0);
    check("err_count_clean", 32'(err_count), 32'd0);

    // Unrepresentable requests.
    run1("e_i2048", 3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048, 32'h00000013, 1'b1);
    run1("e_b_odd", 3'(BTYPE), 7'b1100011, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 32'h00000013, 1'b1);
    run1("e_u_low", 3'(UTYPE), 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 32'h00000013, 1'b1);
    run1("e_type7", 3'd7, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
    @(negedge clk);
    exp_errs = 4;
    check("err_count_4", 32'(err_count), 32'd4);

    // Backpressure: three back-to-back requests against a stalled consumer.
    out_ready = 1'b0;
    @(negedge clk);
    set_req(3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    in_valid = 1'b1; #1;
    check("bp_rdy_a", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_imm = 32'd2; #1;
    check("bp_rdy_b", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_imm = 32'd3; #1;
    check("bp_rdy_c", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("bp_hold_rdy", 32'(in_ready), 32'd0);
    check("bp_hold_out", out_instr, 32'h00100093);
    out_ready = 1'b1; #1;
    got.delete();
    for (int c = 0; c < 10; c++) begin
      if (out_valid) got.push_back(out_instr);
      drop = in_valid && in_ready;
      @(negedge clk);
      if (drop) in_valid = 1'b0;
      #1;
    end
    check("bp_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) begin
      check("bp_w0", got[0], 32'h00100093);
      check("bp_w1", got[1], 32'h00200093);
      check("bp_w2", got[2], 32'h00300093);
    end

    // Random valid/ready soak of I-type requests against a scoreboard.
    acc = 1'b0;
    cur = '0;
    sbq.delete();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (acc) in_valid = 1'b0;
      if (!in_valid && ($urandom_range(0, 3) != 0)) begin
        v = int'($urandom_range(0, 6000)) - 3000;
        set_req(3'(ITYPE), 7'b0010011, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 7'($urandom_range(0, 127)), 32'(v));
        if (v >= -2048 && v <= 2047)
          cur = {1'b0, in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
        else
          cur = {1'b1, 32'h0000_0013};
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) check("soak_extra", 32'(out_valid), 32'd0);
        else begin
          exp_item = sbq.pop_front();
          if (exp_item[32]) exp_errs++;
          check("soak_instr", out_instr, exp_item[31:0]);
          check("soak_err", 32'(out_err), 32'(exp_item[32]));
        end
      end
      if (acc) sbq.push_back(cur);
    end
    @(negedge clk);
    if (acc) in_valid = 1'b0;
    out_ready = 1'b1; #1;
    for (int c = 0; c < 20 && sbq.size() > 0; c++) begin
      if (out_valid) begin
        exp_item = sbq.pop_front();
        if (exp_item[32]) exp_errs++;
        check("drain_instr", out_instr, exp_item[31:0]);
        check("drain_err", 32'(out_err), 32'(exp_item[32]));
      end
      @(negedge clk); #1;
    end
    check("soak_left", 32'(sbq.size()), 32'd0);
    @(negedge clk);
    check("soak_err_count", 32'(err_count), 32'(exp_errs));

    // Reset with two words in flight.
    out_ready = 1'b0;
    @(negedge clk);
    set_req(3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    in_valid = 1'b1;
    @(negedge clk);
    in_imm = 32'd4096;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_count", 32'(err_count), 32'd0);
    check("rst_mid_instr", out_instr, 32'h0000_0013);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_emit", 32'(seen), 32'd0);
    run1("post_rst", 3'(ITYPE), 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 32'h00500093, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
